// File: rtl/minicpu_datamem_if.sv
// minicpu data-memory bus, core side (master) to memory side (slave).
//
// Bus protocol: the core drives ram_addr with at most one of the active-low
// strobes ram_rd_ / ram_wr_ low. Reads complete in the same cycle:
// ram_d_out is combinational from ram_addr while ram_rd_ is low and is 0
// otherwise. Writes are captured at the next rising clk edge. There is no
// wait state and no ready signal on this bus; every access completes.
interface minicpu_datamem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d_in;
  logic [DATA_W-1:0] ram_d_out;
  logic              ram_rd_;
  logic              ram_wr_;

  // Core side: issues addresses, strobes and write data.
  modport master (
    output ram_addr,
    output ram_d_in,
    output ram_rd_,
    output ram_wr_,
    input  ram_d_out
  );

  // Memory side: decodes the access and returns read data.
  modport slave (
    input  ram_addr,
    input  ram_d_in,
    input  ram_rd_,
    input  ram_wr_,
    output ram_d_out
  );
endinterface

// File: rtl/minicpu_datamem.sv
// minicpu data memory: RAM below IO_BASE plus a small I/O page holding a TX
// stream FIFO, an RX stream FIFO, a status register with sticky error bits,
// and an optional free-running timer.
//
// I/O page (offsets from IO_BASE):
//   +0 TXDATA (write)  +1 STATUS (read)  +2 RXDATA (read, pops)  +3 TIMER
//   STATUS = {2'b00, rx_under, tx_drop, rx_empty, rx_full, tx_empty, tx_full}
//
// Stream handshakes (out_* and in_*): a beat transfers on a rising clk edge
// where valid and ready are both 1. valid never depends on ready, and
// ready never depends on valid, so there are no combinational loops.
//
// Build option: define MINICPU_DATAMEM_TIMER_EN to include the TIMER
// counter; without it the TIMER address reads 0 and no counter exists.
module minicpu_datamem #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] IO_BASE    = 8'hF0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  minicpu_datamem_if.slave  bus,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int RAM_DEPTH = int'(IO_BASE);
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  // FIFO index bits; pointers carry one extra wrap bit so that a full FIFO
  // and an empty FIFO are distinguishable.
  localparam int PW        = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] A_TXDATA = IO_BASE;
  localparam logic [ADDR_W-1:0] A_STATUS = IO_BASE + ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RXDATA = IO_BASE + ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_TIMER  = IO_BASE + ADDR_W'(3);

  // ---------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------
  logic              is_ram;
  logic              wr_act;
  logic              rd_act;
  logic [RAM_AW-1:0] ram_idx;

  // A write always wins over a simultaneous read; only read side effects
  // (RX pop, sticky clear) are suppressed, the read data is still driven.
  // Nothing changes state while reset is asserted.
  always_comb begin
    is_ram  = (bus.ram_addr < IO_BASE);
    wr_act  = rst_ && !bus.ram_wr_;
    rd_act  = rst_ && !bus.ram_rd_ && bus.ram_wr_;
    ram_idx = bus.ram_addr[RAM_AW-1:0];
  end

  // ---------------------------------------------------------------------
  // RAM (contents intentionally survive reset)
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [RAM_DEPTH];

  // RAM write port.
  always_ff @(posedge clk) begin
    if (wr_act && is_ram) begin
      mem_q[ram_idx] <= bus.ram_d_in;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [FIFO_DEPTH];
  logic [PW:0]       tx_wptr_q, tx_wptr_d;
  logic [PW:0]       tx_rptr_q, tx_rptr_d;
  logic [PW:0]       rx_wptr_q, rx_wptr_d;
  logic [PW:0]       rx_rptr_q, rx_rptr_d;
  logic              tx_drop_q, tx_drop_d;
  logic              rx_under_q, rx_under_d;

  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_pop, tx_push, tx_drop_evt, tx_wr_req;
  logic              rx_pop, rx_push, rx_under_evt, rx_rd_req;
  logic              status_rd;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] timer_val;

  // Occupancy flags from the wrap-bit pointers.
  always_comb begin
    tx_empty = (tx_wptr_q == tx_rptr_q);
    tx_full  = (tx_wptr_q[PW] != tx_rptr_q[PW]) &&
               (tx_wptr_q[PW-1:0] == tx_rptr_q[PW-1:0]);
    rx_empty = (rx_wptr_q == rx_rptr_q);
    rx_full  = (rx_wptr_q[PW] != rx_rptr_q[PW]) &&
               (rx_wptr_q[PW-1:0] == rx_rptr_q[PW-1:0]);
  end

  // Stream-facing outputs; out_data reads 0 when nothing is queued.
  always_comb begin
    out_valid = !tx_empty;
    out_data  = tx_empty ? '0 : tx_mem_q[tx_rptr_q[PW-1:0]];
    in_ready  = !rx_full;
    rx_head   = rx_empty ? '0 : rx_mem_q[rx_rptr_q[PW-1:0]];
  end

  // Transfer events. A TX pop on a full FIFO frees the slot for a push in
  // the same cycle; an RX pop on a full FIFO does not admit a push because
  // in_ready was already low.
  always_comb begin
    tx_pop       = rst_ && out_valid && out_ready;
    tx_wr_req    = wr_act && (bus.ram_addr == A_TXDATA);
    tx_push      = tx_wr_req && (!tx_full || tx_pop);
    tx_drop_evt  = tx_wr_req && tx_full && !tx_pop;

    rx_push      = rst_ && in_valid && in_ready;
    rx_rd_req    = rd_act && (bus.ram_addr == A_RXDATA);
    rx_pop       = rx_rd_req && !rx_empty;
    rx_under_evt = rx_rd_req && rx_empty;

    status_rd    = rd_act && (bus.ram_addr == A_STATUS);
  end

  // Next-state for pointers and sticky bits; a new event beats the clear.
  always_comb begin
    tx_wptr_d  = tx_wptr_q + (PW+1)'(tx_push);
    tx_rptr_d  = tx_rptr_q + (PW+1)'(tx_pop);
    rx_wptr_d  = rx_wptr_q + (PW+1)'(rx_push);
    rx_rptr_d  = rx_rptr_q + (PW+1)'(rx_pop);
    tx_drop_d  = (tx_drop_q  && !status_rd) || tx_drop_evt;
    rx_under_d = (rx_under_q && !status_rd) || rx_under_evt;
  end

  // Pointer and sticky-bit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_drop_q  <= 1'b0;
      rx_under_q <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_drop_q  <= tx_drop_d;
      rx_under_q <= rx_under_d;
    end
  end

  // FIFO storage writes; the push strobes are already gated by reset.
  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q[PW-1:0]] <= bus.ram_d_in;
    end
    if (rx_push) begin
      rx_mem_q[rx_wptr_q[PW-1:0]] <= in_data;
    end
  end

  // ---------------------------------------------------------------------
  // Optional free-running timer
  // ---------------------------------------------------------------------
`ifdef MINICPU_DATAMEM_TIMER_EN
  logic [DATA_W-1:0] timer_q, timer_d;

  // Wraps naturally from all-ones to 0.
  always_comb begin
    timer_d = timer_q + DATA_W'(1);
  end

  // Timer register; a read sees the value before this cycle's increment.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_val = timer_q;
`else
  assign timer_val = '0;
`endif

  // ---------------------------------------------------------------------
  // Read data mux (combinational, same-cycle)
  // ---------------------------------------------------------------------
  always_comb begin
    status = DATA_W'({rx_under_q, tx_drop_q, rx_empty, rx_full,
                      tx_empty, tx_full});
  end

  // Drives 0 whenever no read is strobed, and for unmapped I/O addresses.
  always_comb begin
    bus.ram_d_out = '0;
    if (!bus.ram_rd_) begin
      if (is_ram) begin
        bus.ram_d_out = mem_q[ram_idx];
      end else begin
        case (bus.ram_addr)
          A_STATUS: bus.ram_d_out = status;
          A_RXDATA: bus.ram_d_out = rx_head;
          A_TIMER:  bus.ram_d_out = timer_val;
          default:  bus.ram_d_out = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_minicpu_datamem.sv
// Bench for minicpu_datamem: directed scenarios followed by random traffic,
// all checked against a queue/array reference model of the memory map.
module tb_minicpu_datamem;

  localparam int         AW    = 8;
  localparam int         DW    = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] IOB   = 8'hF0;
  localparam logic [7:0] A_TX  = IOB;
  localparam logic [7:0] A_ST  = IOB + 8'd1;
  localparam logic [7:0] A_RX  = IOB + 8'd2;
  localparam logic [7:0] A_TM  = IOB + 8'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  minicpu_datamem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  minicpu_datamem #(
    .ADDR_W(AW), .DATA_W(DW), .IO_BASE(IOB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .bus       (bus.slave),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] ram_m  [0:239];
  bit            ram_ok [0:239];
  logic [DW-1:0] exp_q[$];   // expected TX stream, in order
  logic [DW-1:0] rx_q[$];    // RX entries waiting to be read
  bit            drop_m, under_m;
  logic [DW-1:0] timer_m;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic rd_n, input logic wr_n,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic ordy, input logic ival,
                       input logic [7:0] idat);
    rst_         = r;
    bus.ram_rd_  = rd_n;
    bus.ram_wr_  = wr_n;
    bus.ram_addr = a;
    bus.ram_d_in = d;
    out_ready    = ordy;
    in_valid     = ival;
    in_data      = idat;
  endtask

  function automatic logic [7:0] model_status();
    return {2'b00, under_m, drop_m, 1'(rx_q.size() == 0),
            1'(rx_q.size() == DEPTH), 1'(exp_q.size() == 0),
            1'(exp_q.size() == DEPTH)};
  endfunction

  // Check all outputs against the model, then advance one clock and update
  // the model with what that edge should have done. Called after negedge.
  task automatic tick();
    logic [7:0] exp_rd;
    bit         known;
    bit         wr, rd, tx_pop, rx_push, new_drop, new_under;
    #2;
    known  = 1'b1;
    exp_rd = 8'h00;
    if (!bus.ram_rd_) begin
      if (bus.ram_addr < IOB) begin
        exp_rd = ram_m[bus.ram_addr];
        known  = ram_ok[bus.ram_addr];
      end else if (bus.ram_addr == A_ST) begin
        exp_rd = model_status();
      end else if (bus.ram_addr == A_RX) begin
        exp_rd = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      end else if (bus.ram_addr == A_TM) begin
`ifdef MINICPU_DATAMEM_TIMER_EN
        exp_rd = timer_m;
`else
        exp_rd = 8'h00;
`endif
      end
    end
    if (known) check_eq("ram_d_out", bus.ram_d_out, exp_rd);
    check_eq("out_valid", out_valid, exp_q.size() > 0);
    check_eq("out_data", out_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    check_eq("in_ready", in_ready, rx_q.size() < DEPTH);

    @(posedge clk);
    if (!rst_) begin
      exp_q.delete();
      rx_q.delete();
      drop_m  = 1'b0;
      under_m = 1'b0;
      timer_m = 8'h00;
    end else begin
      wr        = !bus.ram_wr_;
      rd        = !bus.ram_rd_ && !wr;
      tx_pop    = (exp_q.size() > 0) && out_ready;
      rx_push   = in_valid && (rx_q.size() < DEPTH);
      new_drop  = 1'b0;
      new_under = 1'b0;
      if (tx_pop) void'(exp_q.pop_front());
      if (wr && bus.ram_addr < IOB) begin
        ram_m[bus.ram_addr]  = bus.ram_d_in;
        ram_ok[bus.ram_addr] = 1'b1;
      end
      if (wr && bus.ram_addr == A_TX) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.ram_d_in);
        else new_drop = 1'b1;
      end
      if (rd && bus.ram_addr == A_RX) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        else new_under = 1'b1;
      end
      if (rx_push) rx_q.push_back(in_data);
      if (rd && bus.ram_addr == A_ST) begin
        drop_m  = 1'b0;
        under_m = 1'b0;
      end
      drop_m  = drop_m | new_drop;
      under_m = under_m | new_under;
      timer_m = timer_m + 8'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, ordy, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int sel, r;
    logic [7:0] a;
    for (int i = 0; i < 240; i++) ram_ok[i] = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    exp_q.delete(); rx_q.delete();
    drop_m = 1'b0; under_m = 1'b0; timer_m = 8'h00;
    @(posedge clk);
    @(negedge clk);
    tick();

    // Reset state and RAM write/read-back.
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("reset_status", bus.ram_d_out, 8'h0A);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("ram_readback", bus.ram_d_out, 8'h5A);
    tick();
    drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("rd_idle_zero", bus.ram_d_out, 8'h00);
    tick();

    // TX fill past full, then drain.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, A_TX, 8'(i), 1'b0, 1'b0, 8'h00);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("tx_full_status", bus.ram_d_out, 8'h19);
    tick();
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      #1 check_eq("tx_drain", out_data, 8'(i));
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("tx_empty_status", bus.ram_d_out, 8'h0A);
    tick();

    // RX fill to full with a held fifth beat, then read out.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA0 + 8'(i));
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5);
    #1 check_eq("rx_full_ready", in_ready, 1'b0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, A_RX, 8'h00, 1'b0, i <= 2, 8'hA5);
      #1 check_eq("rx_read", bus.ram_d_out, 8'hA0 + 8'(i));
      tick();
    end

    // Underflow, sticky report, then clear.
    drive(1'b1, 1'b0, 1'b1, A_RX, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("rx_under_data", bus.ram_d_out, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("rx_under_sticky", bus.ram_d_out, 8'h2A);
    tick();
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("sticky_cleared", bus.ram_d_out, 8'h0A);
    tick();

    // Reset in the middle of TX traffic with a write pending.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, A_TX, 8'h30 + 8'(i), 1'b0, 1'b0, 8'h00);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, A_TX, 8'h77, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b1, A_ST, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("midrst_valid", out_valid, 1'b0);
    check_eq("midrst_status", bus.ram_d_out, 8'h0A);
    tick();

    // Timer wrap: 256 edges after the reset edge.
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 256; i++) begin
      idle(1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1, A_TM, 8'h00, 1'b0, 1'b0, 8'h00);
    #1 check_eq("timer_wrap", bus.ram_d_out, 8'h00);
    tick();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = 8'($urandom_range(0, 15));
      else if (sel == 4) a = 8'($urandom_range(236, 239));
      else if (sel == 9) a = 8'($urandom_range(240, 255));
      else               a = IOB + 8'($urandom_range(0, 3));
      r = $urandom_range(0, 19);
      drive(($urandom_range(0, 99) != 0),
            !(r <= 7 || r == 14),
            !((r >= 8 && r <= 13) || r == 14),
            a, 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 8'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
